param_seq_alu: RTL and testbench

- Parametrised multicycle ALU core: one-hot sequencer plus its own datapath.
- Provides add, sub, radix-2 Booth signed multiply and non-restoring divide at WIDTH bits.
- Successor to the fixed 8-bit control unit; the datapath now sits inside the block, with operand/result ports, busy status and divide-by-zero handling.
- Sits between the operand register file and the result writeback stage.

---
 rtl/param_seq_alu.sv | 211 +++++++++++++++++++++
 tb/tb_param_seq_alu.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_seq_alu.sv
// param_seq_alu: multicycle add/sub, signed Booth multiply and non-restoring divide at WIDTH bits.
// Define SIGNED_DIV_EN to make divide two's complement (adds the DIV_FIX state).
module param_seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             begin_op,
    input  logic [1:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             busy,
    output logic             alu_done
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    // Two guard bits keep the Booth accumulator and the shifted remainder sign-correct.
    localparam int AW = WIDTH + 2;
`ifdef SIGNED_DIV_EN
    localparam int NS = 11;
`else
    localparam int NS = 10;
`endif

    typedef enum logic [NS-1:0] {
        IDLE      = NS'(1),
        ARITH     = NS'(2),
        MUL_LOAD  = NS'(4),
        MUL_OP    = NS'(8),
        MUL_SHIFT = NS'(16),
        DIV_LOAD  = NS'(32),
        DIV_SHIFT = NS'(64),
        DIV_OP    = NS'(128),
        DIV_FINAL = NS'(256),
        DONE      = NS'(512)
`ifdef SIGNED_DIV_EN
        , DIV_FIX = NS'(1024)
`endif
    } state_t;

    state_t state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, q_q, q_d, lo_q, lo_d, hi_q, hi_d;
    logic [AW-1:0] acc_q, acc_d, m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic sub_q, sub_d, qm1_q, qm1_d, ovf_q, ovf_d, dbz_q, dbz_d;
    logic [WIDTH-1:0] b_eff, sum;
`ifdef SIGNED_DIV_EN
    logic neg_a_q, neg_a_d, neg_b_q, neg_b_d;
`endif

    always_comb begin
        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        q_d = q_q;
        lo_d = lo_q;
        hi_d = hi_q;
        acc_d = acc_q;
        m_d = m_q;
        cnt_d = cnt_q;
        sub_d = sub_q;
        qm1_d = qm1_q;
        ovf_d = ovf_q;
        dbz_d = dbz_q;
`ifdef SIGNED_DIV_EN
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
`endif
        b_eff = sub_q ? ~b_q : b_q;
        sum = a_q + b_eff + {{(WIDTH-1){1'b0}}, sub_q};
        unique case (state_q)
            IDLE: if (begin_op) begin
                a_d = a;
                b_d = b;
                sub_d = opcode[0];
                ovf_d = 1'b0;
                dbz_d = 1'b0;
                state_d = opcode[1] ? (opcode[0] ? DIV_LOAD : MUL_LOAD) : ARITH;
            end
            ARITH: begin
                lo_d = sum;
                hi_d = '0;
                ovf_d = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
                state_d = DONE;
            end
            MUL_LOAD: begin
                acc_d = '0;
                q_d = a_q;
                qm1_d = 1'b0;
                m_d = {{2{b_q[WIDTH-1]}}, b_q};
                cnt_d = CNT_W'(WIDTH);
                state_d = MUL_OP;
            end
            MUL_OP: begin
                acc_d = ({q_q[0], qm1_q} == 2'b01) ? acc_q + m_q :
                        ({q_q[0], qm1_q} == 2'b10) ? acc_q - m_q : acc_q;
                state_d = MUL_SHIFT;
            end
            MUL_SHIFT: begin
                acc_d = {acc_q[AW-1], acc_q[AW-1:1]};
                q_d = {acc_q[0], q_q[WIDTH-1:1]};
                qm1_d = q_q[0];
                cnt_d = cnt_q - CNT_W'(1);
                state_d = (cnt_d == '0) ? DONE : MUL_OP;
                if (cnt_d == '0) begin
                    lo_d = q_d;
                    hi_d = acc_d[WIDTH-1:0];
                end
            end
            DIV_LOAD: if (b_q == '0) begin
                lo_d = '1;
                hi_d = a_q;
                dbz_d = 1'b1;
                state_d = DONE;
            end else begin
                acc_d = '0;
                cnt_d = CNT_W'(WIDTH);
`ifdef SIGNED_DIV_EN
                q_d = a_q[WIDTH-1] ? -a_q : a_q;
                m_d = {2'b00, (b_q[WIDTH-1] ? -b_q : b_q)};
                neg_a_d = a_q[WIDTH-1];
                neg_b_d = b_q[WIDTH-1];
`else
                q_d = a_q;
                m_d = {2'b00, b_q};
`endif
                state_d = DIV_SHIFT;
            end
            DIV_SHIFT: begin
                acc_d = {acc_q[AW-2:0], q_q[WIDTH-1]};
                q_d = {q_q[WIDTH-2:0], 1'b0};
                state_d = DIV_OP;
            end
            DIV_OP: begin
                acc_d = acc_q[AW-1] ? acc_q + m_q : acc_q - m_q;
                q_d = {q_q[WIDTH-1:1], ~acc_d[AW-1]};
                cnt_d = cnt_q - CNT_W'(1);
                state_d = (cnt_d == '0) ? DIV_FINAL : DIV_SHIFT;
            end
            DIV_FINAL: begin
                acc_d = acc_q[AW-1] ? acc_q + m_q : acc_q;
`ifdef SIGNED_DIV_EN
                state_d = DIV_FIX;
`else
                lo_d = q_q;
                hi_d = acc_d[WIDTH-1:0];
                state_d = DONE;
`endif
            end
`ifdef SIGNED_DIV_EN
            DIV_FIX: begin
                lo_d = (neg_a_q ^ neg_b_q) ? -q_q : q_q;
                hi_d = neg_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                state_d = DONE;
            end
`endif
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            q_q <= '0;
            lo_q <= '0;
            hi_q <= '0;
            acc_q <= '0;
            m_q <= '0;
            cnt_q <= '0;
            sub_q <= 1'b0;
            qm1_q <= 1'b0;
            ovf_q <= 1'b0;
            dbz_q <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            q_q <= q_d;
            lo_q <= lo_d;
            hi_q <= hi_d;
            acc_q <= acc_d;
            m_q <= m_d;
            cnt_q <= cnt_d;
            sub_q <= sub_d;
            qm1_q <= qm1_d;
            ovf_q <= ovf_d;
            dbz_q <= dbz_d;
`ifdef SIGNED_DIV_EN
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
`endif
        end
    end

    assign result_lo = lo_q;
    assign result_hi = hi_q;
    assign overflow = ovf_q;
    assign div_by_zero = dbz_q;
    assign busy = state_q != IDLE;
    assign alu_done = state_q == DONE;
endmodule

// File: tb/tb_param_seq_alu.sv
// tb_param_seq_alu: randomized and directed checks of param_seq_alu against an arithmetic reference model.
module tb_param_seq_alu;
    localparam int W = 8;
    localparam int W2 = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic begin_op = 1'b0;
    logic [1:0] opcode = '0;
    logic [W-1:0] a = '0, b = '0;
    logic [W-1:0] result_lo, result_hi;
    logic overflow, div_by_zero, busy, alu_done;

    logic begin16 = 1'b0;
    logic [1:0] op16 = '0;
    logic [W2-1:0] a16 = '0, b16 = '0;
    logic [W2-1:0] lo16, hi16;
    logic ov16, dz16, busy16, done16;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    param_seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .begin_op(begin_op), .opcode(opcode), .a(a), .b(b),
        .result_lo(result_lo), .result_hi(result_hi), .overflow(overflow),
        .div_by_zero(div_by_zero), .busy(busy), .alu_done(alu_done)
    );

    param_seq_alu #(.WIDTH(W2)) dut16 (
        .clk(clk), .reset(reset), .begin_op(begin16), .opcode(op16), .a(a16), .b(b16),
        .result_lo(lo16), .result_hi(hi16), .overflow(ov16),
        .div_by_zero(dz16), .busy(busy16), .alu_done(done16)
    );

    // Reference: plain integer arithmetic on the operand values.
    function automatic void model(input logic [1:0] op, input logic [W-1:0] x, y,
                                  output logic [W-1:0] lo, hi, output logic ov, dz, output int lat);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint ux = longint'(x);
        longint uy = longint'(y);
        longint r, q, rm;
        longint smax = (longint'(1) << (W - 1)) - 1;
        longint smin = -(longint'(1) << (W - 1));
        lo = '0; hi = '0; ov = 1'b0; dz = 1'b0; lat = 2;
        if (op[1] == 1'b0) begin
            r = op[0] ? sx - sy : sx + sy;
            lo = r[W-1:0];
            ov = (r > smax) || (r < smin);
        end else if (op == 2'b10) begin
            r = sx * sy;
            lo = r[W-1:0];
            hi = r[2*W-1:W];
            lat = 2 * W + 2;
        end else if (y == '0) begin
            lo = '1;
            hi = x;
            dz = 1'b1;
        end else begin
`ifdef SIGNED_DIV_EN
            q = sx / sy;
            rm = sx % sy;
            lat = 2 * W + 4;
`else
            q = ux / uy;
            rm = ux % uy;
            lat = 2 * W + 3;
`endif
            lo = q[W-1:0];
            hi = rm[W-1:0];
        end
    endfunction

    // Drives one operation; lat counts edges from the accept edge to the first alu_done cycle.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] x, y,
                         output int lat, output int busy_n, output logic pulse_ok);
        @(negedge clk);
        opcode = op; a = x; b = y; begin_op = 1'b1;
        @(posedge clk); #1;
        begin_op = 1'b0; a = W'($urandom); b = W'($urandom); opcode = 2'($urandom);
        lat = 1; busy_n = 0;
        while (!alu_done && lat < 100) begin
            busy_n += int'(busy);
            @(posedge clk); #1;
            lat++;
        end
        busy_n += int'(busy);
        @(posedge clk); #1;
        pulse_ok = !alu_done && !busy;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({result_lo, result_hi, overflow, div_by_zero, busy, alu_done} !== '0) begin
            n_bad++;
            $display("FAIL reset: got lo=%h hi=%h ov=%b dz=%b busy=%b done=%b, want all zero",
                     result_lo, result_hi, overflow, div_by_zero, busy, alu_done);
        end
        reset = 1'b0;
    endtask

    task automatic test_addsub();
        logic [W-1:0] xs [4] = '{8'd100, 8'd5, 8'h7F, 8'h80};
        logic [W-1:0] ys [4] = '{8'd50, 8'd7, 8'h01, 8'h01};
        logic [1:0] ops [4] = '{2'b00, 2'b01, 2'b00, 2'b01};
        logic [W-1:0] x, y, elo, ehi;
        logic [1:0] op;
        logic eov, edz, pok;
        int elat, lat, bn;
        for (int i = 0; i < 24; i++) begin
            x = i < 4 ? xs[i] : W'($urandom);
            y = i < 4 ? ys[i] : W'($urandom);
            op = i < 4 ? ops[i] : {1'b0, 1'($urandom)};
            issue(op, x, y, lat, bn, pok);
            model(op, x, y, elo, ehi, eov, edz, elat);
            n_vec++;
            if ({result_hi, result_lo, overflow, div_by_zero} !== {ehi, elo, eov, edz} ||
                lat != elat || bn != elat || !pok) begin
                n_bad++;
                $display("FAIL addsub op=%0d a=%h b=%h: got lo=%h hi=%h ov=%b dz=%b lat=%0d busy=%0d pulse=%b, want lo=%h hi=%h ov=%b dz=%b lat=%0d",
                         op, x, y, result_lo, result_hi, overflow, div_by_zero, lat, bn, pok, elo, ehi, eov, edz, elat);
            end
        end
    endtask

    task automatic test_mul();
        logic [W-1:0] xs [5] = '{8'hFD, 8'h80, 8'h80, 8'h7F, 8'h00};
        logic [W-1:0] ys [5] = '{8'h07, 8'h80, 8'h7F, 8'hFF, 8'h55};
        logic [W-1:0] x, y, elo, ehi;
        logic eov, edz, pok;
        int elat, lat, bn;
        for (int i = 0; i < 20; i++) begin
            x = i < 5 ? xs[i] : W'($urandom);
            y = i < 5 ? ys[i] : W'($urandom);
            issue(2'b10, x, y, lat, bn, pok);
            model(2'b10, x, y, elo, ehi, eov, edz, elat);
            n_vec++;
            if ({result_hi, result_lo, overflow, div_by_zero} !== {ehi, elo, eov, edz} ||
                lat != elat || bn != elat || !pok) begin
                n_bad++;
                $display("FAIL mul a=%h b=%h: got hi:lo=%h%h ov=%b dz=%b lat=%0d busy=%0d pulse=%b, want %h%h ov=%b dz=%b lat=%0d",
                         x, y, result_hi, result_lo, overflow, div_by_zero, lat, bn, pok, ehi, elo, eov, edz, elat);
            end
        end
    endtask

    task automatic test_div();
        logic [W-1:0] xs [6] = '{8'd200, 8'hF3, 8'hFF, 8'h00, 8'h80, 8'h07};
        logic [W-1:0] ys [6] = '{8'd7, 8'd4, 8'h01, 8'h05, 8'hFF, 8'hF9};
        logic [W-1:0] x, y, elo, ehi;
        logic eov, edz, pok;
        int elat, lat, bn;
        for (int i = 0; i < 22; i++) begin
            x = i < 6 ? xs[i] : W'($urandom);
            y = i < 6 ? ys[i] : W'($urandom_range(1, 255));
            issue(2'b11, x, y, lat, bn, pok);
            model(2'b11, x, y, elo, ehi, eov, edz, elat);
            n_vec++;
            if ({result_hi, result_lo, overflow, div_by_zero} !== {ehi, elo, eov, edz} ||
                lat != elat || bn != elat || !pok) begin
                n_bad++;
                $display("FAIL div a=%h b=%h: got q=%h r=%h ov=%b dz=%b lat=%0d busy=%0d pulse=%b, want q=%h r=%h ov=%b dz=%b lat=%0d",
                         x, y, result_lo, result_hi, overflow, div_by_zero, lat, bn, pok, elo, ehi, eov, edz, elat);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat, bn;
        logic pok;
        issue(2'b11, 8'd13, 8'd0, lat, bn, pok);
        n_vec++;
        if ({result_lo, result_hi, div_by_zero, overflow} !== {8'hFF, 8'h0D, 1'b1, 1'b0} || lat != 2 || !pok) begin
            n_bad++;
            $display("FAIL div_zero: got lo=%h hi=%h dz=%b ov=%b lat=%0d pulse=%b, want lo=ff hi=0d dz=1 ov=0 lat=2",
                     result_lo, result_hi, div_by_zero, overflow, lat, pok);
        end
        issue(2'b00, 8'd1, 8'd2, lat, bn, pok);
        n_vec++;
        if ({result_lo, result_hi, div_by_zero} !== {8'd3, 8'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL dz_clear: got lo=%h hi=%h dz=%b, want lo=03 hi=00 dz=0", result_lo, result_hi, div_by_zero);
        end
    endtask

    task automatic test_back_to_back();
        int t, gap;
        @(negedge clk);
        opcode = 2'b00; a = 8'd1; b = 8'd2; begin_op = 1'b1;
        t = 0;
        do begin @(posedge clk); #1; t++; end while (!alu_done && t < 50);
        gap = 0;
        do begin @(posedge clk); #1; gap++; end while (!alu_done && gap < 50);
        n_vec++;
        if (gap != 3 || result_lo !== 8'd3) begin
            n_bad++;
            $display("FAIL back_to_back: got gap=%0d lo=%h, want gap=3 lo=03", gap, result_lo);
        end
        begin_op = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        opcode = 2'b10; a = 8'h12; b = 8'h34; begin_op = 1'b1;
        @(posedge clk); #1;
        begin_op = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        begin_op = 1'b1; opcode = 2'b00;
        @(posedge clk); #1;
        begin_op = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({result_lo, result_hi, overflow, div_by_zero, busy, alu_done} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: got lo=%h hi=%h ov=%b dz=%b busy=%b done=%b, want all zero",
                     result_lo, result_hi, overflow, div_by_zero, busy, alu_done);
        end
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            seen += int'(alu_done) + int'(busy);
        end
        n_vec++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL reset_quiet: got %0d busy/done cycles after reset, want 0", seen);
        end
    endtask

    task automatic test_wide();
        logic [W2-1:0] x, y;
        longint p;
        int lat;
        for (int i = 0; i < 6; i++) begin
            x = i == 0 ? 16'h8000 : W2'($urandom);
            y = i == 0 ? 16'h8000 : W2'($urandom);
            @(negedge clk);
            op16 = 2'b10; a16 = x; b16 = y; begin16 = 1'b1;
            @(posedge clk); #1;
            begin16 = 1'b0;
            lat = 1;
            while (!done16 && lat < 100) begin @(posedge clk); #1; lat++; end
            p = longint'($signed(x)) * longint'($signed(y));
            n_vec++;
            if ({hi16, lo16} !== p[31:0] || lat != 2 * W2 + 2) begin
                n_bad++;
                $display("FAIL wide_mul a=%h b=%h: got %h%h lat=%0d, want %h lat=%0d",
                         x, y, hi16, lo16, lat, p[31:0], 2 * W2 + 2);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_addsub();
        test_mul();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
